dmem_arbiter: RTL and testbench

- Shares one single-ported synchronous RAM between two requesters: the instruction-fetch port and the MEM-stage data port (ce/we/addr/sel/data as driven by the memory-access stage).
- Sequences each access through a fixed three-cycle handshake.
- Raises a stall request while any requester is waiting.
- Sits between the pipeline and the RAM.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arb_pick.sv | 44 ++++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared types and constants.
// Imported by the arbiter, its grant picker and the bus interface.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Fetch, data and RAM signals around the dmem arbiter.
// slave = arbiter view, master = pipeline/RAM view.
interface dmem_arbiter_if;

  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;

  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;

  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  logic        stall_req_o;

  modport slave (
    input  if_ce_i, if_addr_i,
    output if_data_o, if_ack_o,
    input  mem_ce_i, mem_we_i, mem_addr_i,
    input  mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o,
    output ram_ce_o, ram_we_o, ram_addr_o,
    output ram_sel_o, ram_data_o,
    input  ram_data_i,
    output stall_req_o
  );

  modport master (
    output if_ce_i, if_addr_i,
    input  if_data_o, if_ack_o,
    output mem_ce_i, mem_we_i, mem_addr_i,
    output mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o,
    input  ram_ce_o, ram_we_o, ram_addr_o,
    input  ram_sel_o, ram_data_o,
    output ram_data_i,
    input  stall_req_o
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Grant decision between fetch and data port.
// Data wins unless fetch has waited STARVE_LIMIT grants.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_ce,
  input  logic mem_ce,
  output logic grant,
  output gnt_e gnt_id
);

  localparam logic [CNT_W-1:0] Limit =
    CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic             starved;

  assign starved = (cnt == Limit);
  assign grant   = idle & (if_ce | mem_ce);

  always_comb begin
    gnt_id = GNT_MEM;
    if (if_ce && (!mem_ce || starved))
      gnt_id = GNT_IF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (idle) begin
      if (!if_ce || gnt_id == GNT_IF)
        cnt <= '0;
      else if (!starved)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous RAM between fetch and MEM stage.
// Each access runs IDLE -> ACCESS -> RESP.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_e      state, state_nxt;
  gnt_e        gnt_q;
  gnt_e        gnt_id;
  logic        grant;
  logic        null_acc;
  logic        resp;
  logic        if_ack;
  logic        mem_ack;

  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_data;

  dmem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .idle   (state == IDLE),
    .if_ce  (bus.if_ce_i),
    .mem_ce (bus.mem_ce_i),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  // misaligned SB/SH arrive with no lanes: sequence, but touch nothing
  assign null_acc = bus.mem_we_i
                  & (bus.mem_sel_i == 4'b0000);

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE):
        if (grant) state_nxt = ACCESS;
      (state == ACCESS):
        state_nxt = RESP;
      (state == RESP):
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_q    <= GNT_IF;
      ram_ce   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= ZeroWord;
      ram_sel  <= 4'b0000;
      ram_data <= ZeroWord;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_q <= gnt_id;
        if (gnt_id == GNT_IF) begin
          ram_ce   <= ChipEnable;
          ram_we   <= 1'b0;
          ram_addr <= word_align(bus.if_addr_i);
          ram_sel  <= 4'b1111;
          ram_data <= ZeroWord;
        end else begin
          ram_ce   <= ChipEnable & ~null_acc;
          ram_we   <= (bus.mem_we_i == WriteEnable)
                    & ~null_acc;
          ram_addr <= word_align(bus.mem_addr_i);
          ram_sel  <= bus.mem_sel_i;
          ram_data <= bus.mem_data_i;
        end
      end else if (state == ACCESS) begin
        ram_ce <= 1'b0;
        ram_we <= 1'b0;
      end
    end
  end

  assign resp    = (state == RESP);
  assign if_ack  = resp & (gnt_q == GNT_IF);
  assign mem_ack = resp & (gnt_q == GNT_MEM);

  assign bus.if_ack_o   = if_ack;
  assign bus.mem_ack_o  = mem_ack;
  assign bus.if_data_o  = if_ack ? bus.ram_data_i
                                 : ZeroWord;
  assign bus.mem_data_o = mem_ack ? bus.ram_data_i
                                  : ZeroWord;

  assign bus.ram_ce_o   = ram_ce;
  assign bus.ram_we_o   = ram_we;
  assign bus.ram_addr_o = ram_addr;
  assign bus.ram_sel_o  = ram_sel;
  assign bus.ram_data_o = ram_data;

  assign bus.stall_req_o =
      (bus.if_ce_i  & ~if_ack)
    | (bus.mem_ce_i & ~mem_ack);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, corner sequences,
// random traffic against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .CNT_W        (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram      [256];
  logic [31:0] ram_init [256];
  logic [31:0] ref_mem  [256];
  logic [31:0] rdata;
  logic        ram_load = 1'b0;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= ram_init[i];
    end else if (bus.ram_ce_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_sel_o[b])
            ram[bus.ram_addr_o[9:2]][8*b +: 8]
              <= bus.ram_data_o[8*b +: 8];
      end else begin
        rdata <= ram[bus.ram_addr_o[9:2]];
      end
    end
  end

  assign bus.ram_data_i = rdata;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_ram();
    ram_load = 1'b1;
    @(posedge clk);
    #1;
    ram_load = 1'b0;
  endtask

  task automatic clr_req();
    bus.if_ce_i    = 1'b0;
    bus.if_addr_i  = '0;
    bus.mem_ce_i   = 1'b0;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = '0;
    bus.mem_sel_i  = '0;
    bus.mem_data_i = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ram_ce"},   32'(bus.ram_ce_o), 0);
    chk({tag, "_ram_we"},   32'(bus.ram_we_o), 0);
    chk({tag, "_ram_addr"}, bus.ram_addr_o, 0);
    chk({tag, "_ram_sel"},  32'(bus.ram_sel_o), 0);
    chk({tag, "_ram_data"}, bus.ram_data_o, 0);
    chk({tag, "_if_ack"},   32'(bus.if_ack_o), 0);
    chk({tag, "_mem_ack"},  32'(bus.mem_ack_o), 0);
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic        e_ce;
    logic        e_we;
    logic [31:0] e_rdata;
    logic [31:0] e_word;
  } vec_t;

  vec_t tab[7];

  logic [3:0] sels[8];

  // transaction-level model state for the random phase
  int          t, free_at, acc_at, ack_at, starve;
  logic        ack_if, e_ce, e_we, e_rdchk;
  logic [31:0] e_rd;
  logic        if_pend, mem_pend;
  logic        p_if_ack, p_mem_ack;
  logic        x_if_ack, x_mem_ack;

  initial begin
    vec_t v;
    int   n;
    int   acks;
    int   order[5];
    logic both;
    logic [31:0] w;

    clr_req();
    sels = '{4'hF, 4'h1, 4'h2, 4'h4,
             4'h8, 4'h3, 4'hC, 4'h0};

    tab[0] = '{1'b1, 1'b0, 32'h104, 4'h0, 32'h0,
               32'h104, 4'hF, 1'b1, 1'b0,
               32'h11223344, 32'h11223344};
    tab[1] = '{1'b0, 1'b1, 32'h201, 4'h4, 32'hABABABAB,
               32'h200, 4'h4, 1'b1, 1'b1,
               32'h0, 32'h55AB7788};
    tab[2] = '{1'b0, 1'b0, 32'h200, 4'hF, 32'h0,
               32'h200, 4'hF, 1'b1, 1'b0,
               32'h55AB7788, 32'h55AB7788};
    tab[3] = '{1'b0, 1'b1, 32'h302, 4'h0, 32'h12345678,
               32'h300, 4'h0, 1'b0, 1'b0,
               32'h0, 32'hCAFEF00D};
    tab[4] = '{1'b0, 1'b0, 32'h300, 4'h3, 32'h0,
               32'h300, 4'h3, 1'b1, 1'b0,
               32'hCAFEF00D, 32'hCAFEF00D};
    tab[5] = '{1'b1, 1'b0, 32'h3FE, 4'h0, 32'h0,
               32'h3FC, 4'hF, 1'b1, 1'b0,
               32'hDEADBEEF, 32'hDEADBEEF};
    tab[6] = '{1'b0, 1'b1, 32'h3FF, 4'h8, 32'h5A5A5A5A,
               32'h3FC, 4'h8, 1'b1, 1'b1,
               32'h0, 32'h5AADBEEF};

    for (int i = 0; i < 256; i++)
      ram_init[i] = 32'h1000_0000 | 32'(i);
    ram_init[8'h41] = 32'h11223344;
    ram_init[8'h80] = 32'h55667788;
    ram_init[8'hC0] = 32'hCAFEF00D;
    ram_init[8'hFF] = 32'hDEADBEEF;
    load_ram();
    chk_reset("reset");
    chk("reset_stall", 32'(bus.stall_req_o), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // directed single accesses
    foreach (tab[i]) begin
      v = tab[i];
      if (v.is_if) begin
        bus.if_ce_i   = 1'b1;
        bus.if_addr_i = v.addr;
      end else begin
        bus.mem_ce_i   = 1'b1;
        bus.mem_we_i   = v.we;
        bus.mem_addr_i = v.addr;
        bus.mem_sel_i  = v.sel;
        bus.mem_data_i = v.wdata;
      end
      #1;
      chk($sformatf("v%0d_stall_n", i),
          32'(bus.stall_req_o), 1);
      tick();
      chk($sformatf("v%0d_addr", i), bus.ram_addr_o, v.e_addr);
      chk($sformatf("v%0d_sel", i),
          32'(bus.ram_sel_o), 32'(v.e_sel));
      chk($sformatf("v%0d_ce", i),
          32'(bus.ram_ce_o), 32'(v.e_ce));
      chk($sformatf("v%0d_we", i),
          32'(bus.ram_we_o), 32'(v.e_we));
      chk($sformatf("v%0d_wdata", i), bus.ram_data_o, v.wdata);
      chk($sformatf("v%0d_stall_n1", i),
          32'(bus.stall_req_o), 1);
      tick();
      chk($sformatf("v%0d_if_ack", i),
          32'(bus.if_ack_o), 32'(v.is_if));
      chk($sformatf("v%0d_mem_ack", i),
          32'(bus.mem_ack_o), 32'(!v.is_if));
      chk($sformatf("v%0d_stall_n2", i),
          32'(bus.stall_req_o), 0);
      chk($sformatf("v%0d_ce_resp", i), 32'(bus.ram_ce_o), 0);
      chk($sformatf("v%0d_we_resp", i), 32'(bus.ram_we_o), 0);
      if (v.is_if)
        chk($sformatf("v%0d_if_data", i),
            bus.if_data_o, v.e_rdata);
      else if (!v.we)
        chk($sformatf("v%0d_mem_data", i),
            bus.mem_data_o, v.e_rdata);
      clr_req();
      tick();
      chk($sformatf("v%0d_word", i),
          ram[v.e_addr[9:2]], v.e_word);
      chk($sformatf("v%0d_ack_idle", i),
          32'(bus.if_ack_o | bus.mem_ack_o), 0);
    end

    // both ports held: expect M,M,M,M,I
    bus.if_ce_i    = 1'b1;
    bus.if_addr_i  = 32'h104;
    bus.mem_ce_i   = 1'b1;
    bus.mem_addr_i = 32'h200;
    bus.mem_sel_i  = 4'hF;
    n    = 0;
    both = 1'b0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      tick();
      if (bus.if_ack_o && bus.mem_ack_o) both = 1'b1;
      if (bus.mem_ack_o) begin
        order[n] = 1;
        n++;
      end else if (bus.if_ack_o) begin
        order[n] = 0;
        n++;
      end
    end
    chk("starve_nacks", 32'(n), 5);
    chk("starve_both_acks", 32'(both), 0);
    for (int k = 0; k < 5; k++)
      chk($sformatf("starve_order%0d", k),
          (k < n) ? 32'(order[k]) : 32'hFFFF_FFFF,
          (k < LIMIT) ? 32'd1 : 32'd0);
    clr_req();
    tick();
    tick();

    // async reset while in ACCESS
    w = ram[8'h40];
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = 1'b1;
    bus.mem_addr_i = 32'h100;
    bus.mem_sel_i  = 4'hF;
    bus.mem_data_i = 32'h77777777;
    tick();
    chk("arst_pre_ce", 32'(bus.ram_ce_o), 1);
    chk("arst_pre_we", 32'(bus.ram_we_o), 1);
    #1;
    rst = 1'b0;
    #1;
    chk_reset("arst");
    clr_req();
    tick();
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      acks += int'(bus.if_ack_o) + int'(bus.mem_ack_o);
    end
    chk("arst_no_ack", 32'(acks), 0);
    chk("arst_ram_kept", ram[8'h40], w);

    // ce high for one cycle only
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = 1'b1;
    bus.mem_addr_i = 32'h084;
    bus.mem_sel_i  = 4'h3;
    bus.mem_data_i = 32'hBEEFBEEF;
    tick();
    bus.mem_ce_i = 1'b0;
    #1;
    chk("drop_ce", 32'(bus.ram_ce_o), 1);
    chk("drop_we", 32'(bus.ram_we_o), 1);
    chk("drop_stall", 32'(bus.stall_req_o), 0);
    tick();
    chk("drop_ack", 32'(bus.mem_ack_o), 1);
    chk("drop_word", ram[8'h21], 32'h1000BEEF);
    tick();
    chk("drop_ack_gone", 32'(bus.mem_ack_o), 0);
    clr_req();

    // random traffic vs model
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram_init[i] = $urandom;
      ref_mem[i]  = ram_init[i];
    end
    load_ram();
    @(negedge clk);
    rst = 1'b1;
    tick();
    free_at   = 0;
    acc_at    = -1;
    ack_at    = -1;
    starve    = 0;
    ack_if    = 1'b0;
    e_ce      = 1'b0;
    e_we      = 1'b0;
    e_rdchk   = 1'b0;
    e_rd      = '0;
    if_pend   = 1'b0;
    mem_pend  = 1'b0;
    p_if_ack  = 1'b0;
    p_mem_ack = 1'b0;
    for (t = 0; t < 2000; t++) begin
      if (!if_pend || p_if_ack) begin
        if_pend = ($urandom_range(0, 2) != 0);
        bus.if_ce_i   = if_pend;
        bus.if_addr_i = 32'($urandom_range(0, 1023));
      end
      if (!mem_pend || p_mem_ack) begin
        mem_pend = ($urandom_range(0, 2) != 0);
        bus.mem_ce_i   = mem_pend;
        bus.mem_we_i   = $urandom_range(0, 1) == 1;
        bus.mem_addr_i = 32'($urandom_range(0, 1023));
        bus.mem_data_i = $urandom;
        bus.mem_sel_i  = bus.mem_we_i
                       ? sels[$urandom_range(0, 7)]
                       : 4'($urandom_range(1, 15));
      end
      #1;
      x_if_ack  = (t == ack_at) && ack_if;
      x_mem_ack = (t == ack_at) && !ack_if;
      chk("rnd_if_ack",
          32'(bus.if_ack_o), 32'(x_if_ack));
      chk("rnd_mem_ack",
          32'(bus.mem_ack_o), 32'(x_mem_ack));
      chk("rnd_stall", 32'(bus.stall_req_o),
          32'((bus.if_ce_i & !x_if_ack)
            | (bus.mem_ce_i & !x_mem_ack)));
      chk("rnd_ram_ce", 32'(bus.ram_ce_o),
          32'((t == acc_at) && e_ce));
      chk("rnd_ram_we", 32'(bus.ram_we_o),
          32'((t == acc_at) && e_we));
      if (x_if_ack)
        chk("rnd_if_data", bus.if_data_o, e_rd);
      if (x_mem_ack && e_rdchk)
        chk("rnd_mem_data", bus.mem_data_o, e_rd);

      if (t >= free_at) begin
        if (bus.if_ce_i || bus.mem_ce_i) begin
          ack_if = bus.if_ce_i
                 && (!bus.mem_ce_i || starve >= LIMIT);
          if (ack_if) begin
            e_ce    = 1'b1;
            e_we    = 1'b0;
            e_rdchk = 1'b1;
            e_rd    = ref_mem[bus.if_addr_i[9:2]];
          end else if (bus.mem_we_i) begin
            e_ce    = bus.mem_sel_i != 0;
            e_we    = bus.mem_sel_i != 0;
            e_rdchk = 1'b0;
            for (int b = 0; b < 4; b++)
              if (bus.mem_sel_i[b])
                ref_mem[bus.mem_addr_i[9:2]][8*b +: 8]
                  = bus.mem_data_i[8*b +: 8];
          end else begin
            e_ce    = 1'b1;
            e_we    = 1'b0;
            e_rdchk = 1'b1;
            e_rd    = ref_mem[bus.mem_addr_i[9:2]];
          end
          acc_at  = t + 1;
          ack_at  = t + 2;
          free_at = t + 3;
        end
        if (!bus.if_ce_i || ack_if && ack_at == t + 2)
          starve = 0;
        else if (starve < LIMIT)
          starve++;
      end
      p_if_ack  = x_if_ack;
      p_mem_ack = x_mem_ack;
      tick();
    end
    clr_req();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
